// File: rtl/pc_sequencer.sv
// Program-counter and instruction-fetch sequencer. Selects and registers the next PC, drives the fetch handshake and counts taken control transfers.
// Optional misaligned-target trap: define MISALIGN_TRAP_EN.
module pc_sequencer #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000,
    parameter int                CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             imem_ack,
    input  logic             stall,
    input  logic [1:0]       branch_type,
    input  logic             cond_satisfied,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  rs1_val,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  link_addr,
    output logic             imem_req,
    output logic             instr_valid,
    output logic             redirect,
    output logic [CNT_W-1:0] taken_cnt,
    output logic             misalign_err
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [XLEN-1:0]   pc_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [XLEN-1:0]   pc_plus4_s;
    logic [XLEN-1:0]   pc_imm_s;
    logic [XLEN-1:0]   jalr_sum_s;
    logic [XLEN-1:0]   target_s;
    logic [XLEN-1:0]   load_pc_s;
    logic              taken_s;
    logic              commit_s;
    logic              redirect_s;
    logic              trap_s;
    logic              imem_req_s;
    logic              instr_valid_s;

    assign pc_plus4_s = pc_r + XLEN'(32'd4);
    assign pc_imm_s   = pc_r + imm;
    assign jalr_sum_s = rs1_val + imm;

    // Target selection by branch type; cond_satisfied only matters for conditional branches
    always_comb begin
        taken_s  = 1'b0;
        target_s = pc_plus4_s;
        case (branch_type)
            2'b00: begin
                taken_s  = 1'b0;
                target_s = pc_plus4_s;
            end
            2'b01: begin
                if (cond_satisfied) begin
                    taken_s  = 1'b1;
                    target_s = pc_imm_s;
                end else begin
                    taken_s  = 1'b0;
                    target_s = pc_plus4_s;
                end
            end
            2'b10: begin
                taken_s  = 1'b1;
                target_s = pc_imm_s;
            end
            2'b11: begin
                taken_s  = 1'b1;
                target_s = jalr_sum_s & {{(XLEN-1){1'b1}}, 1'b0};
            end
            default: begin
                taken_s  = 1'b0;
                target_s = pc_plus4_s;
            end
        endcase
    end

    assign commit_s   = (state_r == ST_EXEC) && !stall;
    assign redirect_s = commit_s && taken_s;

`ifdef MISALIGN_TRAP_EN
    logic misalign_r;

    // A taken transfer to a non-word-aligned target halts instead of loading pc
    assign trap_s    = redirect_s && target_s[1];
    assign load_pc_s = target_s;

    // Sticky trap flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_r <= 1'b0;
        end else if (trap_s) begin
            misalign_r <= 1'b1;
        end
    end

    assign misalign_err = misalign_r;
`else
    assign trap_s       = 1'b0;
    assign load_pc_s    = target_s & {{(XLEN-2){1'b1}}, 2'b00};
    assign misalign_err = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_BOOT: begin
                state_next_s = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (stall) begin
                    state_next_s = ST_EXEC;
                end else if (trap_s) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_next_s = ST_HALT;
            end
            default: begin
                state_next_s = ST_BOOT;
            end
        endcase
    end

    // State, pc and saturating taken counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_BOOT;
            pc_r    <= RESET_PC;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (commit_s && !trap_s) begin
                pc_r <= load_pc_s;
            end
            if (redirect_s && !trap_s && !(&cnt_r)) begin
                cnt_r <= cnt_r + CNT_W'(1'b1);
            end
        end
    end

    // Strobe decode from the current state
    always_comb begin
        imem_req_s    = 1'b0;
        instr_valid_s = 1'b0;
        case (state_r)
            ST_BOOT: begin
                imem_req_s    = 1'b0;
                instr_valid_s = 1'b0;
            end
            ST_FETCH: begin
                imem_req_s    = 1'b1;
                instr_valid_s = 1'b0;
            end
            ST_EXEC: begin
                imem_req_s    = 1'b0;
                instr_valid_s = 1'b1;
            end
            ST_HALT: begin
                imem_req_s    = 1'b0;
                instr_valid_s = 1'b0;
            end
            default: begin
                imem_req_s    = 1'b0;
                instr_valid_s = 1'b0;
            end
        endcase
    end

    assign pc          = pc_r;
    assign link_addr   = pc_plus4_s;
    assign imem_req    = imem_req_s;
    assign instr_valid = instr_valid_s;
    assign redirect    = redirect_s;
    assign taken_cnt   = cnt_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer (CNT_W=2 so counter saturation is reachable).
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ack;
    logic        stall;
    logic [1:0]  branch_type;
    logic        cond_satisfied;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        imem_req;
    logic        instr_valid;
    logic        redirect;
    logic [1:0]  taken_cnt;
    logic        misalign_err;

    int n_checks = 0;
    int n_fail   = 0;

    pc_sequencer #(.XLEN(32), .RESET_PC(32'h0000_0000), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .imem_ack(imem_ack), .stall(stall),
        .branch_type(branch_type), .cond_satisfied(cond_satisfied),
        .imm(imm), .rs1_val(rs1_val), .pc(pc), .link_addr(link_addr),
        .imem_req(imem_req), .instr_valid(instr_valid), .redirect(redirect),
        .taken_cnt(taken_cnt), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  bt;
        logic        cond;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] cur_pc;
        logic        exp_redir;
        logic [31:0] exp_pc;
        logic [1:0]  exp_cnt;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ins(input logic [1:0] bt, input logic c, input logic [31:0] im,
                           input logic [31:0] r1, input logic st);
        branch_type    = bt;
        cond_satisfied = c;
        imm            = im;
        rs1_val        = r1;
        stall          = st;
    endtask

    // Reset, then walk BOOT -> FETCH -> EXEC with immediate ack
    task automatic reset_to_exec();
        reset    = 1'b1;
        imem_ack = 1'b1;
        set_ins(2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        vecs[0]  = '{2'b00, 1'b1, 32'h0000_0000, 32'h0,        32'h0000_0000, 1'b0, 32'h0000_0004, 2'd0};
        vecs[1]  = '{2'b00, 1'b0, 32'h0000_0000, 32'h0,        32'h0000_0004, 1'b0, 32'h0000_0008, 2'd0};
        vecs[2]  = '{2'b00, 1'b0, 32'h0000_0000, 32'h0,        32'h0000_0008, 1'b0, 32'h0000_000C, 2'd0};
        vecs[3]  = '{2'b10, 1'b0, 32'h0000_00F4, 32'h0,        32'h0000_000C, 1'b1, 32'h0000_0100, 2'd1};
        vecs[4]  = '{2'b01, 1'b0, 32'hFFFF_FFF0, 32'h0,        32'h0000_0100, 1'b0, 32'h0000_0104, 2'd1};
        vecs[5]  = '{2'b01, 1'b1, 32'hFFFF_FFEC, 32'h0,        32'h0000_0104, 1'b1, 32'h0000_00F0, 2'd2};
        vecs[6]  = '{2'b11, 1'b0, 32'h0000_0004, 32'h1001,     32'h0000_00F0, 1'b1, 32'h0000_1004, 2'd3};
        vecs[7]  = '{2'b11, 1'b0, 32'hFFFF_FFF1, 32'h20,       32'h0000_1004, 1'b1, 32'h0000_0010, 2'd3};
        vecs[8]  = '{2'b10, 1'b0, 32'hFFFF_FFF0, 32'h0,        32'h0000_0010, 1'b1, 32'h0000_0000, 2'd3};
        vecs[9]  = '{2'b01, 1'b1, 32'hFFFF_FFFC, 32'h0,        32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 2'd3};
        vecs[10] = '{2'b00, 1'b0, 32'h0000_0000, 32'h0,        32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 2'd3};

        // Reset state
        reset    = 1'b1;
        imem_ack = 1'b1;
        set_ins(2'b10, 1'b1, 32'h40, 32'h0, 1'b0);
        tick();
        tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_cnt", {30'd0, taken_cnt}, 32'd0);
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
        reset = 1'b0;
        set_ins(2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        chk("boot_to_fetch_req", {31'd0, imem_req}, 32'd1);
        tick();

        // Instruction table: EXEC, commit, FETCH with immediate ack
        for (int i = 0; i < 11; i++) begin
            set_ins(vecs[i].bt, vecs[i].cond, vecs[i].imm, vecs[i].rs1, 1'b0);
            #1;
            chk($sformatf("v%0d_exec_pc", i), pc, vecs[i].cur_pc);
            chk($sformatf("v%0d_valid", i), {31'd0, instr_valid}, 32'd1);
            chk($sformatf("v%0d_req_exec", i), {31'd0, imem_req}, 32'd0);
            chk($sformatf("v%0d_link", i), link_addr, vecs[i].cur_pc + 32'd4);
            chk($sformatf("v%0d_redirect", i), {31'd0, redirect}, {31'd0, vecs[i].exp_redir});
            tick();
            chk($sformatf("v%0d_next_pc", i), pc, vecs[i].exp_pc);
            chk($sformatf("v%0d_req_fetch", i), {31'd0, imem_req}, 32'd1);
            chk($sformatf("v%0d_valid_fetch", i), {31'd0, instr_valid}, 32'd0);
            chk($sformatf("v%0d_cnt", i), {30'd0, taken_cnt}, {30'd0, vecs[i].exp_cnt});
            tick();
        end

        // Stall during a JALR at 0x200
        reset_to_exec();
        set_ins(2'b10, 1'b0, 32'h200, 32'h0, 1'b0);
        tick();
        tick();
        chk("jal200_pc", pc, 32'h200);
        set_ins(2'b11, 1'b0, 32'h4, 32'h1001, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall%0d_redirect", i), {31'd0, redirect}, 32'd0);
            chk($sformatf("stall%0d_link", i), link_addr, 32'h204);
            tick();
            chk($sformatf("stall%0d_pc", i), pc, 32'h200);
            chk($sformatf("stall%0d_cnt", i), {30'd0, taken_cnt}, 32'd1);
            chk($sformatf("stall%0d_valid", i), {31'd0, instr_valid}, 32'd1);
        end
        stall = 1'b0;
        #1;
        chk("release_redirect", {31'd0, redirect}, 32'd1);
        tick();
        chk("jalr_pc", pc, 32'h1004);
        chk("jalr_cnt", {30'd0, taken_cnt}, 32'd2);

        // FETCH waits for ack
        imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("wait%0d_req", i), {31'd0, imem_req}, 32'd1);
            chk($sformatf("wait%0d_pc", i), pc, 32'h1004);
        end
        imem_ack = 1'b1;
        tick();
        chk("ack_exec_valid", {31'd0, instr_valid}, 32'd1);

        // ack during a stalled EXEC is ignored
        set_ins(2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        chk("ack_in_exec_valid", {31'd0, instr_valid}, 32'd1);
        chk("ack_in_exec_pc", pc, 32'h1004);

        // Reset beats a taken branch on the same edge
        set_ins(2'b10, 1'b0, 32'h40, 32'h0, 1'b0);
        reset = 1'b1;
        tick();
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_cnt", {30'd0, taken_cnt}, 32'd0);
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
        reset = 1'b0;
        tick();
        chk("midrst_fetch_req", {31'd0, imem_req}, 32'd1);

        // Misaligned JAL target
        reset_to_exec();
        set_ins(2'b10, 1'b0, 32'h6, 32'h0, 1'b0);
        #1;
        chk("mis_redirect", {31'd0, redirect}, 32'd1);
        tick();
`ifdef MISALIGN_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mis%0d_pc", i), pc, 32'h0);
            chk($sformatf("mis%0d_err", i), {31'd0, misalign_err}, 32'd1);
            chk($sformatf("mis%0d_req", i), {31'd0, imem_req}, 32'd0);
            chk($sformatf("mis%0d_valid", i), {31'd0, instr_valid}, 32'd0);
            chk($sformatf("mis%0d_cnt", i), {30'd0, taken_cnt}, 32'd0);
            tick();
        end
        reset = 1'b1;
        tick();
        chk("mis_rst_err", {31'd0, misalign_err}, 32'd0);
        reset = 1'b0;
`else
        chk("mis_pc", pc, 32'h4);
        chk("mis_err", {31'd0, misalign_err}, 32'd0);
        chk("mis_cnt", {30'd0, taken_cnt}, 32'd1);
        chk("mis_req", {31'd0, imem_req}, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
